// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 2-bit-digit multiplier.
package seq_mult_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit-product steps per multiply, (n/2)^2, built by repeated addition
  // so the only multiplying hardware in the block stays the array2 cell.
  function automatic int calc_k(input int n);
    int k;
    k = 0;
    for (int x = 0; x < n / 2; x++) begin
      k += n / 2;
    end
    return k;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_array2.sv
// 2x2 unsigned array multiplier cell: AND partial products plus two half adders.
module array2 (
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  output logic [3:0] o_p
);

  logic w_pp00, w_pp01, w_pp10, w_pp11;
  logic w_c1;

  assign w_pp00 = i_x[0] & i_y[0];
  assign w_pp01 = i_x[0] & i_y[1];
  assign w_pp10 = i_x[1] & i_y[0];
  assign w_pp11 = i_x[1] & i_y[1];

  assign w_c1   = w_pp10 & w_pp01;

  assign o_p[0] = w_pp00;
  assign o_p[1] = w_pp10 ^ w_pp01;
  assign o_p[2] = w_pp11 ^ w_c1;
  assign o_p[3] = w_pp11 & w_c1;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: accumulates one 2x2 digit product per cycle
// through a single array2 cell; IDLE -> RUN -> DONE control.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [N+N-1:0]   p
);

  localparam int PW = N + N;
  localparam int H  = N / 2;
  localparam int K  = calc_k(N);
  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int KW = $clog2(K);

  localparam logic [IW-1:0] LAST_IDX = IW'(H - 1);
  localparam logic [KW-1:0] CNT_INIT = KW'(K - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_p;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [KW-1:0]   r_left;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [1:0]      w_da;
  logic [1:0]      w_db;
  logic [3:0]      w_pp;
  logic [IW+1:0]   w_shamt;
  logic [PW-1:0]   w_term;
  logic [PW-1:0]   w_sum;

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_step   = (r_state == RUN) && !abort;
  // r_left counts remaining digit steps; it reaches zero together with i=j=H-1.
  assign w_last   = (r_left == '0);

  assign w_da = r_a[{r_i, 1'b0} +: 2];
  assign w_db = r_b[{r_j, 1'b0} +: 2];

  array2 u_array2 (
    .i_x (w_da),
    .i_y (w_db),
    .o_p (w_pp)
  );

  assign w_shamt = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
  assign w_term  = {{(PW - 4){1'b0}}, w_pp} << w_shamt;
  assign w_sum   = r_acc + w_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start && !abort) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_p    <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_left <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_left <= CNT_INIT;
    end else if (w_step) begin
      r_acc  <= w_sum;
      r_left <= r_left - KW'(1);
      if (r_j == LAST_IDX) begin
        r_j <= '0;
        r_i <= r_i + IW'(1);
      end else begin
        r_j <= r_j + IW'(1);
      end
      if (w_last) begin
        r_p <= w_sum;
      end
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed + randomized bench for seq_mult_ctrl (N=8) against a cycle-level
// reference built from plain a*b arithmetic and the K-edge latency rule.
module tb_seq_mult_ctrl;

  localparam int N = 8;
  localparam int K = (N / 2) * (N / 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          ready;
  logic          busy;
  logic          done;
  logic [2*N-1:0] p;

  int tests;
  int fails;
  logic [2*N-1:0] exp_p;

  seq_mult_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outs(input string tag, input bit e_ready, input bit e_busy,
                          input bit e_done, input logic [2*N-1:0] e_p);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, e_ready});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, e_busy});
    chk({tag, ".done"},  {31'd0, done},  {31'd0, e_done});
    chk({tag, ".p"},     {16'd0, p},     {16'd0, e_p});
  endtask

  // One multiply from IDLE. Edge e=0 samples start. abort_at>=0 raises abort
  // so that it is sampled at edge abort_at+1; poke_at>0 pulses start with
  // a=b=FF sampled at that edge; abort_done raises abort during the DONE cycle.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input int abort_at, input int poke_at,
                        input bit abort_done, input string tag);
    logic [2*N-1:0] prev;
    logic [2*N-1:0] prod;
    bit aborted;
    bit e_busy;
    bit e_done;
    prev    = exp_p;
    prod    = {8'd0, ta} * {8'd0, tb_v};
    aborted = (abort_at >= 0) && (abort_at < K);
    for (int e = 0; e <= K + 2; e++) begin
      if (e == 0) begin
        start = 1'b1;
        a     = ta;
        b     = tb_v;
      end else if (e == poke_at) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
      end
      abort = ((abort_at >= 0) && (e == abort_at + 1)) || (abort_done && (e == K + 1));
      @(posedge clk);
      #1;
      e_busy = (e < K) && !(aborted && (e >= abort_at + 1));
      e_done = !aborted && (e == K);
      chk_outs($sformatf("%s.e%0d", tag, e), !e_busy && !e_done, e_busy, e_done,
               (!aborted && (e >= K)) ? prod : prev);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!aborted) exp_p = prod;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_p = '0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("idle", 1'b1, 1'b0, 1'b0, 16'h0000);

    run_op(8'hFF, 8'hFF, -1, -1, 1'b0, "ff_ff");
    chk("ff_ff.final", {16'd0, p}, 32'h0000_FE01);

    run_op(8'hA5, 8'h3C, -1, -1, 1'b1, "a5_3c");
    chk("a5_3c.final", {16'd0, p}, 32'h0000_26AC);
    run_op(8'h00, 8'h7F, -1, -1, 1'b0, "00_7f");
    chk("00_7f.final", {16'd0, p}, 32'h0000_0000);

    run_op(8'h12, 8'h34, -1, 5, 1'b0, "start_in_run");
    chk("start_in_run.final", {16'd0, p}, 32'h0000_03A8);

    run_op(8'h0F, 8'h0F, -1, -1, 1'b0, "0f_0f");
    chk("0f_0f.final", {16'd0, p}, 32'h0000_00E1);
    run_op(8'h10, 8'h10, 8, -1, 1'b0, "abort_run");
    chk("abort_run.final", {16'd0, p}, 32'h0000_00E1);

    // Reset in the middle of a run.
    a     = 8'h55;
    b     = 8'h66;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("rst_mid", 1'b1, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    exp_p = '0;
    for (int e = 1; e <= K + 4; e++) begin
      @(posedge clk);
      #1;
      chk_outs($sformatf("rst_after.e%0d", e), 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    run_op(8'h02, 8'h03, -1, -1, 1'b0, "02_03");
    chk("02_03.final", {16'd0, p}, 32'h0000_0006);

    // start and abort together in IDLE.
    a     = 8'h33;
    b     = 8'h44;
    start = 1'b1;
    abort = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk_outs($sformatf("start_abort.e%0d", e), 1'b1, 1'b0, 1'b0, exp_p);
    end
    start = 1'b0;
    abort = 1'b0;

    // start held high: the second multiply is accepted at edge K+2.
    a     = 8'h05;
    b     = 8'h07;
    start = 1'b1;
    for (int e = 0; e <= 2 * K + 3; e++) begin
      @(posedge clk);
      #1;
      chk_outs($sformatf("b2b.e%0d", e),
               !(((e < K) || ((e >= K + 2) && (e < 2 * K + 2)))) && !((e == K) || (e == 2 * K + 2)),
               (e < K) || ((e >= K + 2) && (e < 2 * K + 2)),
               (e == K) || (e == 2 * K + 2),
               (e >= K) ? 16'd35 : exp_p);
      if (e == K + 2) start = 1'b0;
    end
    exp_p = 16'd35;

    for (int t = 0; t < 10; t++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      int ab;
      ra = N'($urandom);
      rb = N'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, K + 1)) : -1;
      run_op(ra, rb, ab, -1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: operand width; even, 4..16.
REQ-002 The block SHALL derive constant K = (N/2)*(N/2), default 16: number of 2x2 digit-product steps per multiply.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: request to begin a multiply.
REQ-006 Port abort SHALL be an input, 1 bit: synchronous cancel of an operation in progress.
REQ-007 Port a SHALL be an input, N bits: multiplicand, unsigned.
REQ-008 Port b SHALL be an input, N bits: multiplier, unsigned.
REQ-009 Port ready SHALL be an output, 1 bit: high when start will be accepted.
REQ-010 Port busy SHALL be an output, 1 bit: high while digit products are being accumulated.
REQ-011 Port done SHALL be an output, 1 bit: single-cycle pulse marking p valid for a new result.
REQ-012 Port p SHALL be an output, 2N bits: unsigned product a*b.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Outputs SHALL decode from registered state: ready = IDLE, busy = RUN, done = DONE.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch a and b, clear the 2N-bit accumulator, set digit indices i=j=0 and enter RUN.
REQ-016 In IDLE, start=0 or abort=1 SHALL keep the FSM in IDLE.
REQ-017 In RUN, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-018 Each RUN cycle, the block SHALL feed a_lat[2i+1:2i] and b_lat[2j+1:2j] to one 2x2 multiplier.
REQ-019 Each RUN cycle, the block SHALL add the 4-bit result, zero-extended to 2N bits and shifted left by 2*(i+j), into the accumulator.
REQ-020 j SHALL increment every RUN cycle; on j=N/2-1, j SHALL wrap to 0 and i SHALL increment.
REQ-021 The accumulator SHALL be 2N bits; no overflow is possible, and no carry beyond bit 2N-1 SHALL be kept.
REQ-022 On the RUN cycle with i=j=N/2-1, the block SHALL perform the final accumulation, load p with the final sum and enter DONE.
REQ-023 DONE SHALL last exactly one cycle and then return unconditionally to IDLE; start in DONE SHALL be ignored.
REQ-024 Latency: for start sampled at edge 0, done SHALL be high between edges K and K+1 (16 edges for N=8); the next start SHALL be accepted at edge K+2 at the earliest.
REQ-025 p SHALL hold its value from DONE until the next DONE; it SHALL NOT change during RUN or on abort.
REQ-026 abort=1 in RUN SHALL force IDLE at the next edge, with no done pulse and p unchanged.
REQ-027 abort=1 in DONE SHALL have no effect: done still pulses and p updates.
REQ-028 When abort and start are both high, abort SHALL take priority.

Reset
REQ-029 Asserting rst at any time, including mid-RUN, SHALL immediately force IDLE, clear p, the accumulator, the latched operands and i/j to 0, and drive ready=1, busy=0, done=0.
REQ-030 An operation interrupted by rst SHALL NOT produce a done pulse after reset is released.

Structure
REQ-031 A shared package seq_mult_pkg SHALL hold the state enumeration, the default N and the function computing K from N.
REQ-032 Exactly one instance of the team's existing 2x2 array multiplier cell array2 SHALL be the sole multiplying sub-module; no other multiplication operator SHALL be used.

Verification
REQ-033 A bench SHALL apply N=8, a=0xFF, b=0xFF, start at edge 0 and check done high only between edges 16 and 17 and p=0xFE01.
REQ-034 A bench SHALL apply a=0xA5, b=0x3C and check p=0x26AC; it SHALL then apply a=0x00, b=0x7F and check p=0x0000, with the previous p held until the new DONE.
REQ-035 A bench SHALL start a=0x12, b=0x34, pulse start with a=0xFF, b=0xFF at edge 5, and check the result is p=0x03A8, with no second done.
REQ-036 A bench SHALL multiply 0x0F*0x0F and check p=0x00E1; it SHALL then assert abort at edge 8 of a new 0x10*0x10 run and check IDLE at edge 9, no done, and p still 0x00E1.
REQ-037 A bench SHALL assert rst mid-RUN at edge 7 and check immediate ready=1, busy=0, done=0, p=0; after release, 0x02*0x03 SHALL yield p=0x0006.
REQ-038 A bench SHALL apply start and abort together in IDLE and check the FSM stays in IDLE.
